title_sequencer: RTL and testbench

Parametrised top-level game-flow controller for the VGA shooter. It replaces the fixed two-frame title flasher. It drives an N-frame title animation, a multi-level play phase with a level counter, and separate win/lose end screens. End screens return to the title either on a start press or after an optional timeout. Outputs feed the screen-select mux and the level/enemy spawn logic.

---
 rtl/title_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_title_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/title_sequencer.sv
// title_sequencer: top-level game-flow controller for the VGA shooter.
// The title screen runs an N-frame animation. A start press enters a
// multi-level play phase. Clearing the last level, or a forced win, shows the
// win screen; a death shows the lose screen. An end screen goes back to the
// title on a start press, or after END_TIMEOUT cycles when END_TIMEOUT > 0.
// Define PAUSE_EN to build the pause/resume states. Without it the pause
// input is ignored and paused is tied low.
//
// state       | meaning
// S_TITLE     | title screen, animation running
// S_TITLE_REL | start held on title, waiting for release
// S_PLAY      | gameplay active
// S_PAUSE     | game frozen, waiting for a second pause press
// S_PAUSE_REL | second pause press held, waiting for release
// S_WIN       | win screen, end timer running
// S_LOSE      | lose screen, end timer running
// S_END_REL   | start held on an end screen, waiting for release
module title_sequencer #(
  parameter int FLASH_PERIOD = 20000000,
  parameter int NUM_FRAMES   = 2,
  parameter int NUM_LEVELS   = 1,
  parameter int END_TIMEOUT  = 0,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          win,
  input  logic          lose,
  input  logic          level_done,
  input  logic          pause,
  output logic          title_on,
  output logic [FW-1:0] title_frame,
  output logic          game_on,
  output logic          win_on,
  output logic          lose_on,
  output logic [LW-1:0] level,
  output logic          level_start,
  output logic          paused
);

  localparam int CW = $clog2(FLASH_PERIOD);
  localparam int EW = (END_TIMEOUT > 1) ? $clog2(END_TIMEOUT) : 1;

  localparam logic [CW-1:0] LAST_FLASH = CW'(FLASH_PERIOD - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
  localparam logic [EW-1:0] LAST_END   = EW'((END_TIMEOUT > 0) ? END_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_TITLE,
    S_TITLE_REL,
    S_PLAY,
    S_PAUSE,
    S_PAUSE_REL,
    S_WIN,
    S_LOSE,
    S_END_REL
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_flash_cnt;
  logic [FW-1:0] r_frame;
  logic [LW-1:0] r_level;
  logic [EW-1:0] r_end_cnt;
  logic          r_level_start;
  logic          r_end_win;

  logic          w_flash_wrap;
  logic          w_last_level;
  logic          w_end_hit;
  logic          w_level_adv;
  logic          w_enter_title;
  logic          w_on_end;
  logic          w_unused;

  assign w_flash_wrap  = (r_flash_cnt == LAST_FLASH);
  assign w_last_level  = (r_level == LAST_LEVEL);
  // The end timer only returns to the title when a timeout is configured.
  assign w_end_hit     = (END_TIMEOUT > 0) && (r_end_cnt == LAST_END);
  assign w_on_end      = (r_state == S_WIN) || (r_state == S_LOSE);
  // A level_done pulse on the last level is a win, not an advance.
  assign w_level_adv   = (r_state == S_PLAY) && !lose && !win && level_done && !w_last_level;
  assign w_enter_title = (w_state_next == S_TITLE) && (r_state != S_TITLE);

`ifdef PAUSE_EN
  logic r_pause_armed;

  // Arms the resume path only after pause has been seen low inside S_PAUSE,
  // so the press that entered the pause cannot also leave it.
  always_ff @(posedge clk) begin
    if (!resetn || r_state != S_PAUSE) begin
      r_pause_armed <= 1'b0;
    end else if (!pause) begin
      r_pause_armed <= 1'b1;
    end
  end

  assign w_unused = ^r_end_cnt;
`else
  assign w_unused = ^{r_end_cnt, pause};
`endif

  // State register; reset always lands on the title screen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_TITLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; lose outranks win, and win outranks level_done.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_TITLE: begin
        if (start) w_state_next = S_TITLE_REL;
      end
      S_TITLE_REL: begin
        if (!start) w_state_next = S_PLAY;
      end
      S_PLAY: begin
        if (lose) begin
          w_state_next = S_LOSE;
        end else if (win) begin
          w_state_next = S_WIN;
        end else if (level_done && w_last_level) begin
          w_state_next = S_WIN;
        end
`ifdef PAUSE_EN
        else if (!level_done && pause) begin
          w_state_next = S_PAUSE;
        end
`endif
      end
`ifdef PAUSE_EN
      S_PAUSE: begin
        if (r_pause_armed && pause) w_state_next = S_PAUSE_REL;
      end
      S_PAUSE_REL: begin
        if (!pause) w_state_next = S_PLAY;
      end
`endif
      S_WIN, S_LOSE: begin
        if (start) begin
          w_state_next = S_END_REL;
        end else if (w_end_hit) begin
          w_state_next = S_TITLE;
        end
      end
      S_END_REL: begin
        if (!start) w_state_next = S_TITLE;
      end
      default: w_state_next = S_TITLE;
    endcase
  end

  // Title animation: the flash counter and frame advance only in S_TITLE.
  always_ff @(posedge clk) begin
    if (!resetn || w_enter_title) begin
      r_flash_cnt <= '0;
      r_frame     <= '0;
    end else if (r_state == S_TITLE) begin
      if (w_flash_wrap) begin
        r_flash_cnt <= '0;
        r_frame     <= (r_frame == LAST_FRAME) ? '0 : r_frame + 1'b1;
      end else begin
        r_flash_cnt <= r_flash_cnt + 1'b1;
      end
    end
  end

  // Level index; held through the end screens so the score can be shown.
  always_ff @(posedge clk) begin
    if (!resetn || w_enter_title) begin
      r_level <= '0;
    end else if (w_level_adv) begin
      r_level <= r_level + 1'b1;
    end
  end

  // One-cycle pulse when a level begins, whether from the title or from a
  // level advance. Resuming from a pause is not a new level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_level_start <= 1'b0;
    end else begin
      r_level_start <= ((r_state == S_TITLE_REL) && !start) || w_level_adv;
    end
  end

  // End-screen timer; it runs only while the win or lose screen is shown.
  always_ff @(posedge clk) begin
    if (!resetn || !w_on_end) begin
      r_end_cnt <= '0;
    end else if (END_TIMEOUT > 0) begin
      r_end_cnt <= r_end_cnt + 1'b1;
    end
  end

  // Remembers which end screen S_END_REL must keep displaying.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_end_win <= 1'b0;
    end else if (r_state == S_PLAY) begin
      r_end_win <= (w_state_next == S_WIN);
    end
  end

  assign title_on    = (r_state == S_TITLE) || (r_state == S_TITLE_REL);
  assign game_on     = (r_state == S_PLAY);
  assign win_on      = (r_state == S_WIN)  || ((r_state == S_END_REL) && r_end_win);
  assign lose_on     = (r_state == S_LOSE) || ((r_state == S_END_REL) && !r_end_win);
  assign title_frame = r_frame;
  assign level       = r_level;
  assign level_start = r_level_start;
`ifdef PAUSE_EN
  assign paused      = (r_state == S_PAUSE) || (r_state == S_PAUSE_REL);
`else
  assign paused      = 1'b0;
`endif

endmodule

// File: tb/tb_title_sequencer.sv
// tb_title_sequencer: directed bench for title_sequencer. Two instances share
// the inputs: one with a 10-cycle end-screen timeout, one with no timeout.
// A screen-level model tracks both instances and is compared every cycle.
module tb_title_sequencer;

  localparam int FP  = 4;
  localparam int NF  = 3;
  localparam int NL  = 3;
  localparam int ET1 = 10;
  localparam int ET0 = 0;
`ifdef PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic win = 1'b0;
  logic lose = 1'b0;
  logic level_done = 1'b0;
  logic pause = 1'b0;

  logic       t1, g1, w1, l1, p1, ls1;
  logic [1:0] fr1, lv1;
  logic       t0, g0, w0, l0, p0, ls0;
  logic [1:0] fr0, lv0;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  title_sequencer #(.FLASH_PERIOD(FP), .NUM_FRAMES(NF), .NUM_LEVELS(NL), .END_TIMEOUT(ET1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .win(win), .lose(lose),
    .level_done(level_done), .pause(pause),
    .title_on(t1), .title_frame(fr1), .game_on(g1), .win_on(w1), .lose_on(l1),
    .level(lv1), .level_start(ls1), .paused(p1)
  );

  title_sequencer #(.FLASH_PERIOD(FP), .NUM_FRAMES(NF), .NUM_LEVELS(NL), .END_TIMEOUT(ET0)) dut0 (
    .clk(clk), .resetn(resetn), .start(start), .win(win), .lose(lose),
    .level_done(level_done), .pause(pause),
    .title_on(t0), .title_frame(fr0), .game_on(g0), .win_on(w0), .lose_on(l0),
    .level(lv0), .level_start(ls0), .paused(p0)
  );

  // scr: 0 title, 1 play, 2 win, 3 lose, 4 paused; hold = waiting for release
  typedef struct {
    int scr;
    bit hold;
    bit armed;
    int fc;
    int fr;
    int lvl;
    int ec;
    bit ls;
  } mdl_t;

  mdl_t m1 = '{default: 0};
  mdl_t m0 = '{default: 0};

  function automatic mdl_t step(mdl_t m, int to, bit rn, bit st, bit wn, bit lo, bit ld, bit ps);
    mdl_t n = m;
    mdl_t clean = '{default: 0};
    n.ls = 1'b0;
    if (!rn) return clean;
    case (m.scr)
      0: begin
        if (!m.hold) begin
          if (m.fc == FP - 1) begin
            n.fc = 0;
            n.fr = (m.fr + 1) % NF;
          end else begin
            n.fc = m.fc + 1;
          end
          if (st) n.hold = 1'b1;
        end else if (!st) begin
          n.scr = 1; n.hold = 1'b0; n.lvl = 0; n.ls = 1'b1;
        end
      end
      1: begin
        if (lo) begin
          n.scr = 3; n.ec = 0;
        end else if (wn) begin
          n.scr = 2; n.ec = 0;
        end else if (ld) begin
          if (m.lvl == NL - 1) begin
            n.scr = 2; n.ec = 0;
          end else begin
            n.lvl = m.lvl + 1; n.ls = 1'b1;
          end
        end else if (PEN && ps) begin
          n.scr = 4; n.hold = 1'b0; n.armed = 1'b0;
        end
      end
      2, 3: begin
        if (m.hold) begin
          if (!st) n = clean;
        end else if (st) begin
          n.hold = 1'b1;
        end else if (to > 0 && m.ec == to - 1) begin
          n = clean;
        end else if (to > 0) begin
          n.ec = m.ec + 1;
        end
      end
      default: begin
        if (m.hold) begin
          if (!ps) begin
            n.scr = 1; n.hold = 1'b0;
          end
        end else if (m.armed && ps) begin
          n.hold = 1'b1;
        end else if (!ps) begin
          n.armed = 1'b1;
        end
      end
    endcase
    return n;
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk) begin
    m1 <= step(m1, ET1, resetn, start, win, lose, level_done, pause);
    m0 <= step(m0, ET0, resetn, start, win, lose, level_done, pause);
  end

  task automatic cmp_model(input string tag, input mdl_t m,
                           input logic t, input logic g, input logic w, input logic l,
                           input logic p, input logic [1:0] fr, input logic [1:0] lv,
                           input logic lst);
    bit bad;
    bad = (t !== (m.scr == 0)) || (g !== (m.scr == 1)) || (w !== (m.scr == 2)) ||
          (l !== (m.scr == 3)) || (p !== (m.scr == 4)) ||
          (fr !== 2'(m.fr)) || (lv !== 2'(m.lvl)) || (lst !== m.ls);
    n_vec++;
    if (bad) begin
      n_mis++;
      $display("FAIL model_%s t=%0t got title/game/win/lose/paused=%b%b%b%b%b frame=%0d level=%0d ls=%b required %b%b%b%b%b frame=%0d level=%0d ls=%b",
               tag, $time, t, g, w, l, p, fr, lv, lst,
               m.scr == 0, m.scr == 1, m.scr == 2, m.scr == 3, m.scr == 4, m.fr, m.lvl, m.ls);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_model("to10", m1, t1, g1, w1, l1, p1, fr1, lv1, ls1);
      cmp_model("to0", m0, t0, g0, w0, l0, p0, fr0, lv0, ls0);
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input int exp);
    logic [31:0] e;
    e = exp;
    n_vec++;
    if (got !== e) begin
      n_mis++;
      $display("FAIL %s got %0d required %0d", name, got, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    start = 1'b1;
    tick(n);
    start = 1'b0;
    tick(1);
  endtask

  initial begin
    int cnt;
    int cnt0;

    tick(2);
    chk_en = 1'b1;
    lit("reset_title_on", 32'(t1), 1);
    lit("reset_game_on", 32'(g1), 0);
    resetn = 1'b1;

    // title animation, 4 cycles per frame, 3 frames
    tick(3);
    lit("frame_c3", 32'(fr1), 0);
    tick(1);
    lit("frame_c4", 32'(fr1), 1);
    tick(4);
    lit("frame_c8", 32'(fr1), 2);
    tick(4);
    lit("frame_c12", 32'(fr1), 0);
    lit("title_on_c12", 32'(t1), 1);
    tick(1);

    // start press held 5 cycles
    start = 1'b1;
    tick(5);
    lit("press_title_on", 32'(t1), 1);
    lit("press_frame_frozen", 32'(fr1), 0);
    start = 1'b0;
    tick(1);
    lit("play_game_on", 32'(g1), 1);
    lit("play_level_start", 32'(ls1), 1);
    lit("play_level", 32'(lv1), 0);
    tick(1);
    lit("play_level_start_off", 32'(ls1), 0);

    // three level_done pulses
    for (int k = 0; k < 2; k++) begin
      level_done = 1'b1;
      tick(1);
      level_done = 1'b0;
      lit("adv_level", 32'(lv1), k + 1);
      lit("adv_level_start", 32'(ls1), 1);
      tick(2);
    end
    level_done = 1'b1;
    tick(1);
    level_done = 1'b0;
    lit("last_win_on", 32'(w1), 1);
    lit("last_level_held", 32'(lv1), 2);
    lit("last_no_level_start", 32'(ls1), 0);

    tick(12);
    lit("win_timeout_title", 32'(t1), 1);
    lit("win_timeout_level", 32'(lv1), 0);
    lit("win_no_timeout_held", 32'(w0), 1);

    // both instances back into play
    press(2);
    press(2);
    tick(1);
    level_done = 1'b1;
    tick(1);
    level_done = 1'b0;
    tick(1);

    // simultaneous win and lose
    win = 1'b1;
    lose = 1'b1;
    tick(1);
    win = 1'b0;
    lose = 1'b0;
    lit("both_lose_on", 32'(l1), 1);
    lit("both_win_on", 32'(w1), 0);
    lit("both_level_held", 32'(lv1), 1);
    press(2);
    lit("ret_title_on", 32'(t1), 1);
    lit("ret_level", 32'(lv1), 0);
    lit("ret_frame", 32'(fr1), 0);

    // lose screen timeout vs no timeout
    press(2);
    lose = 1'b1;
    tick(1);
    lose = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (l1 === 1'b1) cnt++;
      tick(1);
    end
    lit("lose_timeout_len", 32'(cnt), 10);
    lit("lose_timeout_title", 32'(t1), 1);
    cnt0 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (l0 === 1'b1) cnt0++;
      tick(1);
    end
    lit("lose_no_timeout_len", 32'(cnt0), 1000);

`ifdef PAUSE_EN
    press(2);
    press(2);
    tick(1);
    pause = 1'b1;
    tick(2);
    pause = 1'b0;
    tick(1);
    lit("pause_paused", 32'(p1), 1);
    lit("pause_game_off", 32'(g1), 0);
    level_done = 1'b1;
    tick(1);
    level_done = 1'b0;
    win = 1'b1;
    tick(1);
    win = 1'b0;
    lit("pause_level_kept", 32'(lv1), 0);
    lit("pause_win_ignored", 32'(p1), 1);
    pause = 1'b1;
    tick(1);
    lit("pause_rel_paused", 32'(p1), 1);
    pause = 1'b0;
    tick(1);
    lit("resume_game_on", 32'(g1), 1);
    lit("resume_no_level_start", 32'(ls1), 0);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    tick(1);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    lit("rst_pause_title_on", 32'(t1), 1);
    lit("rst_pause_paused", 32'(p1), 0);
    tick(2);
`endif

    // reset in the middle of play
    press(2);
    level_done = 1'b1;
    tick(1);
    level_done = 1'b0;
    lit("mid_level", 32'(lv1), 1);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(1);
    lit("rst_mid_title_on", 32'(t1), 1);
    lit("rst_mid_game_on", 32'(g1), 0);
    lit("rst_mid_level", 32'(lv1), 0);
    tick(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
